// File: rtl/clock_set_ctrl_pkg.sv
// Shared encodings for the front-panel time/alarm set controller.
// State, field and target codes plus BCD wrap limits.
package clock_pkg;

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_EDIT_HH = 3'd1,
      ST_EDIT_MM = 3'd2,
      ST_EDIT_SS = 3'd3,
      ST_COMMIT  = 3'd4
   } state_t;

   typedef enum logic {
      TGT_TIME  = 1'b0,
      TGT_ALARM = 1'b1
   } target_t;

   localparam logic [1:0] FLD_NONE = 2'd0;
   localparam logic [1:0] FLD_HH   = 2'd1;
   localparam logic [1:0] FLD_MM   = 2'd2;
   localparam logic [1:0] FLD_SS   = 2'd3;

   localparam logic [7:0] HH_MAX = 8'h23;
   localparam logic [7:0] MS_MAX = 8'h59;

   // Field indicator shown on the panel for a given controller state.
   function automatic logic [1:0] field_of(input state_t st);
      logic [1:0] f;
      f = FLD_NONE;
      case (st)
         ST_EDIT_HH: f = FLD_HH;
         ST_EDIT_MM: f = FLD_MM;
         ST_EDIT_SS: f = FLD_SS;
         default:    f = FLD_NONE;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Bundle between the debounced buttons / time counter and the set controller.
// master = panel side (buttons, current time), slave = the controller.
interface clock_set_ctrl_if;

   logic       btn_mode;
   logic       btn_alarm;
   logic       btn_next;
   logic       btn_inc;
   logic [7:0] hh_cur;
   logic [7:0] mm_cur;
   logic [7:0] ss_cur;

   logic       ena;
   logic [7:0] hh_in;
   logic [7:0] mm_in;
   logic [7:0] ss_in;
   logic       load;
   logic       put_alarm;
   logic       editing;
   logic [1:0] field_sel;

   modport master (
      output btn_mode, btn_alarm, btn_next, btn_inc,
      output hh_cur, mm_cur, ss_cur,
      input  ena, hh_in, mm_in, ss_in, load, put_alarm, editing, field_sel
   );

   modport slave (
      input  btn_mode, btn_alarm, btn_next, btn_inc,
      input  hh_cur, mm_cur, ss_cur,
      output ena, hh_in, mm_in, ss_in, load, put_alarm, editing, field_sel
   );

endinterface

// File: rtl/clock_set_ctrl_tick_prescaler.sv
// Divides clk down to a single-cycle count-enable pulse every TICK_DIV cycles.
// Counter and pulse are forced to zero whenever run is low.
module tick_prescaler #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic ena
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count_reg;
   logic          ena_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
         ena_reg   <= 1'b0;
      end else if (!run) begin
         count_reg <= '0;
         ena_reg   <= 1'b0;
      end else if (count_reg == LAST) begin
         count_reg <= '0;
         ena_reg   <= 1'b1;
      end else begin
         count_reg <= count_reg + 1'b1;
         ena_reg   <= 1'b0;
      end
   end

   assign ena = ena_reg;

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven HH:MM:SS edit sequencer that commits a BCD time or alarm value,
// and gates the 1 Hz count enable so the clock only advances while running.
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic             clk,
   input  logic             reset,
   clock_set_ctrl_if.slave  bus
);

   state_t     state_reg, state_next;
   target_t    target_reg, target_next;
   logic [7:0] hh_reg, hh_next;
   logic [7:0] mm_reg, mm_next;
   logic [7:0] ss_reg, ss_next;
   logic       load_reg, load_next;
   logic       alarm_reg, alarm_next;
   logic       editing_reg, editing_next;
   logic [1:0] field_reg, field_next;
   logic       run;

   // Out-of-range or non-BCD values snap to 00 rather than propagating garbage.
   function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
      logic [7:0] res;
      if ((val[7:4] > 4'd9) || (val[3:0] > 4'd9) || (val >= max)) begin
         res = 8'h00;
      end else if (val[3:0] == 4'd9) begin
         res = {val[7:4] + 4'd1, 4'd0};
      end else begin
         res = {val[7:4], val[3:0] + 4'd1};
      end
      return res;
   endfunction

   always_comb begin
      state_next  = state_reg;
      target_next = target_reg;
      hh_next     = hh_reg;
      mm_next     = mm_reg;
      ss_next     = ss_reg;

      case (state_reg)
         ST_RUN: begin
            if (bus.btn_mode || bus.btn_alarm) begin
               hh_next     = bus.hh_cur;
               mm_next     = bus.mm_cur;
               ss_next     = bus.ss_cur;
               target_next = bus.btn_mode ? TGT_TIME : TGT_ALARM;
               state_next  = ST_EDIT_HH;
            end
         end

         ST_EDIT_HH: begin
            if (bus.btn_mode) begin
               state_next = ST_RUN;
            end else if (bus.btn_next) begin
               state_next = ST_EDIT_MM;
            end else if (bus.btn_inc) begin
               hh_next = bcd_inc(hh_reg, HH_MAX);
            end
         end

         ST_EDIT_MM: begin
            if (bus.btn_mode) begin
               state_next = ST_RUN;
            end else if (bus.btn_next) begin
               state_next = ST_EDIT_SS;
            end else if (bus.btn_inc) begin
               mm_next = bcd_inc(mm_reg, MS_MAX);
            end
         end

         ST_EDIT_SS: begin
            if (bus.btn_mode) begin
               state_next = ST_RUN;
            end else if (bus.btn_next) begin
               state_next = ST_COMMIT;
            end else if (bus.btn_inc) begin
               ss_next = bcd_inc(ss_reg, MS_MAX);
            end
         end

         ST_COMMIT: begin
            state_next = ST_RUN;
         end

         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   // Output flags are derived from the next state so they change on the same edge as the state.
   always_comb begin
      load_next    = (state_next == ST_COMMIT) && (target_next == TGT_TIME);
      alarm_next   = (state_next == ST_COMMIT) && (target_next == TGT_ALARM);
      editing_next = (state_next == ST_EDIT_HH) || (state_next == ST_EDIT_MM) ||
                     (state_next == ST_EDIT_SS);
      field_next   = field_of(state_next);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_RUN;
         target_reg  <= TGT_TIME;
         hh_reg      <= 8'h00;
         mm_reg      <= 8'h00;
         ss_reg      <= 8'h00;
         load_reg    <= 1'b0;
         alarm_reg   <= 1'b0;
         editing_reg <= 1'b0;
         field_reg   <= FLD_NONE;
      end else begin
         state_reg   <= state_next;
         target_reg  <= target_next;
         hh_reg      <= hh_next;
         mm_reg      <= mm_next;
         ss_reg      <= ss_next;
         load_reg    <= load_next;
         alarm_reg   <= alarm_next;
         editing_reg <= editing_next;
         field_reg   <= field_next;
      end
   end

   // Counting only while RUN persists keeps ena low on the edge that enters an edit,
   // and restarts the full TICK_DIV period after a commit or abort.
   assign run = (state_reg == ST_RUN) && (state_next == ST_RUN);

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .ena   (bus.ena)
   );

   assign bus.hh_in     = hh_reg;
   assign bus.mm_in     = mm_reg;
   assign bus.ss_in     = ss_reg;
   assign bus.load      = load_reg;
   assign bus.put_alarm = alarm_reg;
   assign bus.editing   = editing_reg;
   assign bus.field_sel = field_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl with TICK_DIV=4: directed edits push expected
// commits / ena cycles into queues, a negedge monitor pops and compares.
module tb_clock_set_ctrl;

   typedef struct {
      int         kind;   // 1 = load, 2 = put_alarm
      int         cyc;
      logic [7:0] hh;
      logic [7:0] mm;
      logic [7:0] ss;
   } commit_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   ena_watch = 1'b0;

   commit_t commit_q[$];
   int      ena_q[$];

   clock_set_ctrl_if bus ();

   clock_set_ctrl #(
      .TICK_DIV (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a pulse.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.editing) cmp("ena_in_edit", 32'(bus.ena), 32'd0);
         if (bus.ena && ena_watch) begin
            if (ena_q.size() == 0) begin
               cmp("ena_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
               cmp("ena_cycle", 32'(cyc), 32'(ena_q.pop_front()));
            end
         end
         if (bus.load || bus.put_alarm) begin
            cmp("commit_exclusive", 32'(bus.load & bus.put_alarm), 32'd0);
            if (commit_q.size() == 0) begin
               cmp("commit_unexpected", {bus.hh_in, bus.mm_in, bus.ss_in, 6'd0, bus.put_alarm, bus.load}, 32'd0);
            end else begin
               commit_t e;
               e = commit_q.pop_front();
               cmp("commit_kind", {30'd0, bus.put_alarm, bus.load}, 32'(e.kind));
               cmp("commit_cycle", 32'(cyc), 32'(e.cyc));
               cmp("commit_data", {8'd0, bus.hh_in, bus.mm_in, bus.ss_in}, {8'd0, e.hh, e.mm, e.ss});
            end
         end
      end
   end

   // b = {mode, alarm, next, inc}
   task automatic press(input logic [3:0] b);
      @(negedge clk);
      {bus.btn_mode, bus.btn_alarm, bus.btn_next, bus.btn_inc} = b;
      @(negedge clk);
      {bus.btn_mode, bus.btn_alarm, bus.btn_next, bus.btn_inc} = 4'b0000;
   endtask

   task automatic commit_press(input int kind, input logic [7:0] hh, input logic [7:0] mm,
                               input logic [7:0] ss);
      commit_t e;
      @(negedge clk);
      e.kind = kind; e.cyc = cyc + 1; e.hh = hh; e.mm = mm; e.ss = ss;
      commit_q.push_back(e);
      bus.btn_next = 1'b1;
      @(negedge clk);
      bus.btn_next = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic set_cur(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
      bus.hh_cur = hh; bus.mm_cur = mm; bus.ss_cur = ss;
   endtask

   localparam logic [3:0] B_MODE  = 4'b1000;
   localparam logic [3:0] B_ALARM = 4'b0100;
   localparam logic [3:0] B_NEXT  = 4'b0010;
   localparam logic [3:0] B_INC   = 4'b0001;

   initial begin
      {bus.btn_mode, bus.btn_alarm, bus.btn_next, bus.btn_inc} = 4'b0000;
      set_cur(8'h00, 8'h00, 8'h00);

      // 1: reset state and ena cadence
      repeat (3) @(negedge clk);
      cmp("rst_editing", 32'(bus.editing), 32'd0);
      cmp("rst_field", 32'(bus.field_sel), 32'd0);
      cmp("rst_bufs", {8'd0, bus.hh_in, bus.mm_in, bus.ss_in}, 32'd0);
      cmp("rst_pulses", {29'd0, bus.ena, bus.load, bus.put_alarm}, 32'd0);
      reset = 1'b0;
      ena_watch = 1'b1;
      ena_q.push_back(4); ena_q.push_back(8); ena_q.push_back(12);
      repeat (13) @(negedge clk);
      ena_watch = 1'b0;

      // 2: time set 12:34:56 -> 14:35:56
      set_cur(8'h12, 8'h34, 8'h56);
      press(B_MODE);
      cmp("t2_field_hh", 32'(bus.field_sel), 32'd1);
      cmp("t2_editing", 32'(bus.editing), 32'd1);
      press(B_INC); press(B_INC);
      press(B_NEXT);
      cmp("t2_field_mm", 32'(bus.field_sel), 32'd2);
      press(B_INC);
      press(B_NEXT);
      cmp("t2_field_ss", 32'(bus.field_sel), 32'd3);
      commit_press(1, 8'h14, 8'h35, 8'h56);
      cmp("t2_back_run", {30'd0, bus.editing, 1'b0}, 32'd0);

      // 3: wraps 23->00, 59->00, 09->10, then invalid 6A->00
      set_cur(8'h23, 8'h59, 8'h09);
      press(B_MODE); press(B_INC);
      press(B_NEXT); press(B_INC);
      press(B_NEXT); press(B_INC);
      commit_press(1, 8'h00, 8'h00, 8'h10);
      set_cur(8'h00, 8'h00, 8'h6A);
      press(B_MODE); press(B_NEXT); press(B_NEXT); press(B_INC);
      commit_press(1, 8'h00, 8'h00, 8'h00);

      // 4: alarm set 07:00:00 -> 07:03:00, alarm button ignored while editing
      set_cur(8'h07, 8'h00, 8'h00);
      press(B_ALARM); press(B_NEXT);
      press(B_INC); press(B_ALARM); press(B_INC); press(B_INC);
      cmp("t4_field_mm", 32'(bus.field_sel), 32'd2);
      press(B_NEXT);
      commit_press(2, 8'h07, 8'h03, 8'h00);

      // 5: abort keeps buffers, next beats inc, mode beats alarm
      set_cur(8'h01, 8'h02, 8'h03);
      press(B_MODE); press(B_NEXT); press(B_INC);
      press(B_MODE);
      cmp("t5_abort_edit", 32'(bus.editing), 32'd0);
      cmp("t5_abort_field", 32'(bus.field_sel), 32'd0);
      cmp("t5_abort_bufs", {8'd0, bus.hh_in, bus.mm_in, bus.ss_in}, 32'h0001_0303);
      set_cur(8'h05, 8'h06, 8'h07);
      press(B_MODE);
      press(B_NEXT | B_INC);
      cmp("t5_next_inc_field", 32'(bus.field_sel), 32'd2);
      cmp("t5_next_inc_hh", 32'(bus.hh_in), 32'h05);
      press(B_NEXT);
      commit_press(1, 8'h05, 8'h06, 8'h07);
      set_cur(8'h10, 8'h20, 8'h30);
      press(B_MODE | B_ALARM);
      press(B_NEXT); press(B_NEXT);
      commit_press(1, 8'h10, 8'h20, 8'h30);

      // 6: asynchronous reset in EDIT_SS
      set_cur(8'h11, 8'h22, 8'h33);
      press(B_MODE); press(B_NEXT); press(B_NEXT); press(B_INC);
      cmp("t6_in_ss", 32'(bus.field_sel), 32'd3);
      #2 reset = 1'b1;
      #1;
      cmp("t6_rst_editing", 32'(bus.editing), 32'd0);
      cmp("t6_rst_field", 32'(bus.field_sel), 32'd0);
      cmp("t6_rst_bufs", {8'd0, bus.hh_in, bus.mm_in, bus.ss_in}, 32'd0);
      cmp("t6_rst_pulses", {29'd0, bus.ena, bus.load, bus.put_alarm}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      ena_watch = 1'b1;
      ena_q.push_back(4); ena_q.push_back(8);
      repeat (9) @(negedge clk);
      ena_watch = 1'b0;

      repeat (3) @(negedge clk);
      cmp("ena_q_drained", 32'(ena_q.size()), 32'd0);
      cmp("commit_q_drained", 32'(commit_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
